// File: rtl/rs_issue_ctrl_pkg.sv
// Shared definitions for the reservation-station issue controller.
//   ROB_W       ROB tag width
//   RS_ENTRIES  number of reservation-station slots
//   SLOT_W      slot index width
//   TAG_NONE    tag value meaning "no dependency" / idle CDB
//   slot_state_e  per-slot lifecycle encoding
package rs_issue_ctrl_pkg;

   localparam int ROB_W      = 4;
   localparam int RS_ENTRIES = 16;
   localparam int SLOT_W     = 4;
   localparam int TAG_NONE   = 0;

   typedef enum logic [1:0] {
      SLOT_FREE    = 2'd0,
      SLOT_WAIT    = 2'd1,
      SLOT_READY   = 2'd2,
      SLOT_OFFERED = 2'd3
   } slot_state_e;

endpackage

// File: rtl/rs_age_select.sv
// Age matrix plus oldest-ready picker for the reservation station.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   clr           wipe all age relations (flush)
//   alloc_valid   a slot is being allocated this edge
//   alloc_slot    index of the slot being allocated
//   busy          registered occupancy mask
//   ready         mask of slots eligible for selection
//   sel_valid     at least one ready slot exists
//   sel_slot      oldest ready slot (0 when none)
module rs_age_select #(
   parameter int ENTRIES = 16,
   parameter int SLOT_W  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              alloc_valid,
   input  logic [SLOT_W-1:0] alloc_slot,
   input  logic [ENTRIES-1:0] busy,
   input  logic [ENTRIES-1:0] ready,
   output logic              sel_valid,
   output logic [SLOT_W-1:0] sel_slot
);

   // older_q[j][i] set means slot j was allocated before slot i.
   // Stale bits left behind by a freed slot are harmless: its row and
   // column are rewritten when it is next allocated, and the picker only
   // looks at ready (hence busy) slots.
   logic [ENTRIES-1:0] older_q [ENTRIES];
   logic               blocked;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int j = 0; j < ENTRIES; j++) older_q[j] <= '0;
      end else if (clr) begin
         for (int j = 0; j < ENTRIES; j++) older_q[j] <= '0;
      end else if (alloc_valid) begin
         for (int j = 0; j < ENTRIES; j++) begin
            if (SLOT_W'(j) == alloc_slot) older_q[j] <= '0;
            else                          older_q[j][alloc_slot] <= busy[j];
         end
      end
   end

   always_comb begin
      sel_valid = 1'b0;
      sel_slot  = '0;
      blocked   = 1'b0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         blocked = 1'b0;
         for (int j = 0; j < ENTRIES; j++) begin
            if (ready[j] && older_q[j][i]) blocked = 1'b1;
         end
         if (ready[i] && !blocked) begin
            sel_valid = 1'b1;
            sel_slot  = SLOT_W'(i);
         end
      end
   end

endmodule

// File: rtl/rs_issue_ctrl.sv
// Control half of a reservation station: slot allocation, operand tag
// wakeup from the ALU and memory CDBs, oldest-ready selection and a
// valid/ready issue handshake toward the functional unit.
// Ports:
//   clk_in, rst_n_in        clock, async active-low reset
//   rdy_in                  global enable (low freezes state, blocks issue/dispatch)
//   flush_in                clear every slot at the next edge
//   disp_valid_in/ready_out dispatch handshake; disp_slot_out = slot to be written
//   disp_qj_in, disp_qk_in  source tags of the dispatched instruction
//   cdb_alu_rob_id_in,
//   cdb_mem_rob_id_in       broadcast tags, 0 = idle
//   issue_valid_out/ready_in issue handshake; issue_slot_out = slot offered
//   busy_out                per-slot occupancy
//   full_out, one_left_out  vacancy status from registered occupancy
//
// state   | meaning
// FREE    | slot empty, may be allocated
// WAIT    | occupied, at least one source tag outstanding
// READY   | occupied, operands available, eligible for selection
// OFFERED | presented to the FU without acceptance; locked until accepted
module rs_issue_ctrl #(
   parameter int ENTRIES = 16,
   parameter int ROB_W   = 4
) (
   input  logic                       clk_in,
   input  logic                       rst_n_in,
   input  logic                       rdy_in,
   input  logic                       flush_in,
   input  logic                       disp_valid_in,
   output logic                       disp_ready_out,
   input  logic [ROB_W-1:0]           disp_qj_in,
   input  logic [ROB_W-1:0]           disp_qk_in,
   output logic [$clog2(ENTRIES)-1:0] disp_slot_out,
   input  logic [ROB_W-1:0]           cdb_alu_rob_id_in,
   input  logic [ROB_W-1:0]           cdb_mem_rob_id_in,
   output logic                       issue_valid_out,
   input  logic                       issue_ready_in,
   output logic [$clog2(ENTRIES)-1:0] issue_slot_out,
   output logic [ENTRIES-1:0]         busy_out,
   output logic                       full_out,
   output logic                       one_left_out
);
   import rs_issue_ctrl_pkg::*;

   localparam int SW = $clog2(ENTRIES);
   localparam logic [ROB_W-1:0] TAG_IDLE = ROB_W'(TAG_NONE);

   slot_state_e      st_q   [ENTRIES];
   slot_state_e      st_nxt [ENTRIES];
   logic [ROB_W-1:0] qj_q   [ENTRIES];
   logic [ROB_W-1:0] qk_q   [ENTRIES];
   logic [ROB_W-1:0] qj_nxt [ENTRIES];
   logic [ROB_W-1:0] qk_nxt [ENTRIES];

   logic [ENTRIES-1:0] busy;
   logic [ENTRIES-1:0] ready_mask;
   logic               locked;
   logic [SW-1:0]      off_slot;
   logic [SW-1:0]      free_slot;
   logic               any_free;
   logic [SW:0]        vacant;
   logic               sel_valid;
   logic [SW-1:0]      sel_slot;
   logic               disp_fire;
   logic               handshake;
   logic [ROB_W-1:0]   disp_qj_byp;
   logic [ROB_W-1:0]   disp_qk_byp;

   // A pending tag that matches a live CDB is treated as already produced.
   function automatic logic [ROB_W-1:0] wake(input logic [ROB_W-1:0] tag,
                                             input logic [ROB_W-1:0] cdb_a,
                                             input logic [ROB_W-1:0] cdb_b);
      if (tag != TAG_IDLE && (tag == cdb_a || tag == cdb_b)) return TAG_IDLE;
      return tag;
   endfunction

   // Descending scan so the lowest-index free slot wins.
   always_comb begin
      busy       = '0;
      ready_mask = '0;
      locked     = 1'b0;
      off_slot   = '0;
      free_slot  = '0;
      any_free   = 1'b0;
      vacant     = '0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         busy[i]       = (st_q[i] != SLOT_FREE);
         ready_mask[i] = (st_q[i] == SLOT_READY);
         if (st_q[i] == SLOT_OFFERED) begin
            locked   = 1'b1;
            off_slot = SW'(i);
         end
         if (st_q[i] == SLOT_FREE) begin
            any_free  = 1'b1;
            free_slot = SW'(i);
            vacant    = vacant + (SW+1)'(1);
         end
      end
   end

   rs_age_select #(.ENTRIES(ENTRIES), .SLOT_W(SW)) u_age (
      .clk         (clk_in),
      .rst_n       (rst_n_in),
      .clr         (rdy_in & flush_in),
      .alloc_valid (disp_fire),
      .alloc_slot  (free_slot),
      .busy        (busy),
      .ready       (ready_mask),
      .sel_valid   (sel_valid),
      .sel_slot    (sel_slot)
   );

   assign busy_out        = busy;
   assign full_out        = ~any_free;
   assign one_left_out    = (vacant == (SW+1)'(1));
   assign disp_ready_out  = rdy_in & any_free;
   assign disp_slot_out   = free_slot;
   assign issue_valid_out = rdy_in & ~flush_in & (locked | sel_valid);
   assign issue_slot_out  = locked ? off_slot : sel_slot;
   assign disp_fire       = rdy_in & ~flush_in & disp_valid_in & any_free;
   assign handshake       = issue_valid_out & issue_ready_in;
   assign disp_qj_byp     = wake(disp_qj_in, cdb_alu_rob_id_in, cdb_mem_rob_id_in);
   assign disp_qk_byp     = wake(disp_qk_in, cdb_alu_rob_id_in, cdb_mem_rob_id_in);

   always_comb begin
      for (int i = 0; i < ENTRIES; i++) begin
         st_nxt[i] = st_q[i];
         qj_nxt[i] = qj_q[i];
         qk_nxt[i] = qk_q[i];
      end
      if (rdy_in && flush_in) begin
         for (int i = 0; i < ENTRIES; i++) begin
            st_nxt[i] = SLOT_FREE;
            qj_nxt[i] = TAG_IDLE;
            qk_nxt[i] = TAG_IDLE;
         end
      end else if (rdy_in) begin
         for (int i = 0; i < ENTRIES; i++) begin
            if (st_q[i] != SLOT_FREE) begin
               qj_nxt[i] = wake(qj_q[i], cdb_alu_rob_id_in, cdb_mem_rob_id_in);
               qk_nxt[i] = wake(qk_q[i], cdb_alu_rob_id_in, cdb_mem_rob_id_in);
               if (st_q[i] == SLOT_WAIT && qj_nxt[i] == TAG_IDLE && qk_nxt[i] == TAG_IDLE)
                  st_nxt[i] = SLOT_READY;
            end
         end
         if (handshake)
            st_nxt[issue_slot_out] = SLOT_FREE;
         else if (issue_valid_out && !locked)
            st_nxt[issue_slot_out] = SLOT_OFFERED;
         // The dispatch target is free, so it never collides with the issued slot.
         if (disp_fire) begin
            qj_nxt[free_slot] = disp_qj_byp;
            qk_nxt[free_slot] = disp_qk_byp;
            st_nxt[free_slot] = (disp_qj_byp == TAG_IDLE && disp_qk_byp == TAG_IDLE)
                                ? SLOT_READY : SLOT_WAIT;
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         for (int i = 0; i < ENTRIES; i++) begin
            st_q[i] <= SLOT_FREE;
            qj_q[i] <= TAG_IDLE;
            qk_q[i] <= TAG_IDLE;
         end
      end else begin
         for (int i = 0; i < ENTRIES; i++) begin
            st_q[i] <= st_nxt[i];
            qj_q[i] <= qj_nxt[i];
            qk_q[i] <= qk_nxt[i];
         end
      end
   end

endmodule

// File: tb/tb_rs_issue_ctrl.sv
module tb_rs_issue_ctrl;

   logic        clk_in = 1'b0;
   logic        rst_n_in;
   logic        rdy_in;
   logic        flush_in;
   logic        disp_valid_in;
   logic        disp_ready_out;
   logic [3:0]  disp_qj_in, disp_qk_in;
   logic [3:0]  disp_slot_out;
   logic [3:0]  cdb_alu_rob_id_in, cdb_mem_rob_id_in;
   logic        issue_valid_out;
   logic        issue_ready_in;
   logic [3:0]  issue_slot_out;
   logic [15:0] busy_out;
   logic        full_out, one_left_out;

   rs_issue_ctrl #(.ENTRIES(16), .ROB_W(4)) dut (
      .clk_in            (clk_in),
      .rst_n_in          (rst_n_in),
      .rdy_in            (rdy_in),
      .flush_in          (flush_in),
      .disp_valid_in     (disp_valid_in),
      .disp_ready_out    (disp_ready_out),
      .disp_qj_in        (disp_qj_in),
      .disp_qk_in        (disp_qk_in),
      .disp_slot_out     (disp_slot_out),
      .cdb_alu_rob_id_in (cdb_alu_rob_id_in),
      .cdb_mem_rob_id_in (cdb_mem_rob_id_in),
      .issue_valid_out   (issue_valid_out),
      .issue_ready_in    (issue_ready_in),
      .issue_slot_out    (issue_slot_out),
      .busy_out          (busy_out),
      .full_out          (full_out),
      .one_left_out      (one_left_out)
   );

   always #5 clk_in = ~clk_in;

   int checks   = 0;
   int failures = 0;

   // Reference model: occupancy, outstanding tags, allocation timestamp,
   // and which slot (if any) is currently held on offer.
   bit m_busy [16];
   int m_qj   [16];
   int m_qk   [16];
   int m_age  [16];
   int m_off;
   int m_seq;

   bit          e_iv, e_dready, e_full, e_one;
   int          e_islot, e_dslot;
   logic [15:0] e_busy;

   typedef struct {
      logic        dv;
      logic [3:0]  qj, qk, alu, mem;
      logic        ir, fl;
      logic [15:0] busy;
      logic        iv;
      logic [3:0]  islot, dslot;
      logic        dready, full, one;
   } vec_t;
   vec_t vt[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < 16; i++) begin
         m_busy[i] = 0; m_qj[i] = 0; m_qk[i] = 0; m_age[i] = 0;
      end
      m_off = -1;
   endfunction

   function automatic int byp(input int q);
      if (q != 0 && (q == int'(cdb_alu_rob_id_in) || q == int'(cdb_mem_rob_id_in))) return 0;
      return q;
   endfunction

   function automatic void model_eval();
      int nfree;
      int best;
      bit got;
      nfree = 0; got = 0; best = -1;
      e_dslot = 0; e_busy = '0;
      for (int i = 0; i < 16; i++) begin
         e_busy[i] = m_busy[i];
         if (!m_busy[i]) begin
            nfree++;
            if (!got) begin got = 1; e_dslot = i; end
         end
      end
      e_dready = rdy_in && nfree > 0;
      e_full   = (nfree == 0);
      e_one    = (nfree == 1);
      if (m_off >= 0) begin
         best = m_off;
      end else begin
         for (int i = 0; i < 16; i++)
            if (m_busy[i] && m_qj[i] == 0 && m_qk[i] == 0 && (best < 0 || m_age[i] < m_age[best]))
               best = i;
      end
      e_islot = (best >= 0) ? best : 0;
      e_iv    = rdy_in && !flush_in && best >= 0;
   endfunction

   function automatic void model_step();
      if (!rdy_in) return;
      if (flush_in) begin model_reset(); return; end
      for (int i = 0; i < 16; i++)
         if (m_busy[i]) begin m_qj[i] = byp(m_qj[i]); m_qk[i] = byp(m_qk[i]); end
      if (e_iv && issue_ready_in) begin m_busy[e_islot] = 0; m_off = -1; end
      else if (e_iv) m_off = e_islot;
      if (disp_valid_in && e_dready) begin
         m_busy[e_dslot] = 1;
         m_qj[e_dslot]   = byp(int'(disp_qj_in));
         m_qk[e_dslot]   = byp(int'(disp_qk_in));
         m_age[e_dslot]  = m_seq;
         m_seq++;
      end
   endfunction

   task automatic set_in(input logic dv, input logic [3:0] qj, input logic [3:0] qk,
                         input logic [3:0] alu, input logic [3:0] mem,
                         input logic ir, input logic fl);
      disp_valid_in = dv; disp_qj_in = qj; disp_qk_in = qk;
      cdb_alu_rob_id_in = alu; cdb_mem_rob_id_in = mem;
      issue_ready_in = ir; flush_in = fl;
   endtask

   task automatic mid();
      @(negedge clk_in);
      model_eval();
      chk("model_busy",   busy_out,        e_busy);
      chk("model_ivalid", issue_valid_out, e_iv);
      chk("model_islot",  issue_slot_out,  e_islot);
      chk("model_dslot",  disp_slot_out,   e_dslot);
      chk("model_dready", disp_ready_out,  e_dready);
      chk("model_full",   full_out,        e_full);
      chk("model_one",    one_left_out,    e_one);
   endtask

   task automatic fin();
      @(posedge clk_in);
      model_step();
      #1;
   endtask

   task automatic cyc(input logic dv, input logic [3:0] qj, input logic [3:0] qk,
                      input logic [3:0] alu, input logic [3:0] mem,
                      input logic ir, input logic fl);
      set_in(dv, qj, qk, alu, mem, ir, fl);
      mid();
      fin();
   endtask

   task automatic expect_issue(input string nm, input logic iv, input logic [3:0] slot);
      chk({nm, "_iv"}, issue_valid_out, iv);
      if (iv) chk({nm, "_slot"}, issue_slot_out, slot);
   endtask

   function automatic void add(input logic dv, input logic [3:0] qj, input logic [3:0] qk,
                               input logic [3:0] alu, input logic [3:0] mem,
                               input logic ir, input logic fl, input logic [15:0] busy,
                               input logic iv, input logic [3:0] islot, input logic [3:0] dslot,
                               input logic dready, input logic full, input logic one);
      vec_t v;
      v.dv = dv; v.qj = qj; v.qk = qk; v.alu = alu; v.mem = mem; v.ir = ir; v.fl = fl;
      v.busy = busy; v.iv = iv; v.islot = islot; v.dslot = dslot;
      v.dready = dready; v.full = full; v.one = one;
      vt.push_back(v);
   endfunction

   initial begin
      // Fill all 16 slots with ready entries while the FU stalls.
      for (int k = 0; k < 16; k++)
         add(1, 0, 0, 0, 0, 0, 0, 16'((32'd1 << k) - 1), k > 0, 0, 4'(k), 1, 0, k == 15);
      add(0, 0, 0, 0, 0, 0, 0, 16'hffff, 1, 0, 0, 0, 1, 0);
      add(0, 0, 0, 0, 0, 1, 0, 16'hffff, 1, 0, 0, 0, 1, 0);
      add(0, 0, 0, 0, 0, 0, 0, 16'hfffe, 1, 1, 0, 1, 0, 1);
      add(0, 0, 0, 0, 0, 0, 1, 16'hfffe, 0, 1, 0, 1, 0, 1);
      add(0, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 1, 0, 0);
      // Two waiting entries woken from different buses, younger first.
      add(1, 3, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 1, 0, 0);
      add(1, 0, 5, 0, 0, 0, 0, 16'h0001, 0, 0, 1, 1, 0, 0);
      add(0, 0, 0, 0, 5, 0, 0, 16'h0003, 0, 0, 2, 1, 0, 0);
      add(0, 0, 0, 3, 0, 1, 0, 16'h0003, 1, 1, 2, 1, 0, 0);
      add(0, 0, 0, 0, 0, 1, 0, 16'h0001, 1, 0, 1, 1, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 1, 0, 0);
      // Dispatch-time bypass from the same-cycle ALU CDB.
      add(1, 7, 0, 7, 0, 0, 0, 16'h0000, 0, 0, 0, 1, 0, 0);
      add(0, 0, 0, 0, 0, 1, 0, 16'h0001, 1, 0, 1, 1, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 1, 0, 0);

      rst_n_in = 1'b0; rdy_in = 1'b0;
      set_in(0, 0, 0, 0, 0, 0, 0);
      model_reset(); m_seq = 0;
      #1;
      chk("rst_busy",   busy_out, 16'h0);
      chk("rst_iv",     issue_valid_out, 1'b0);
      chk("rst_islot",  issue_slot_out, 4'h0);
      chk("rst_dslot",  disp_slot_out, 4'h0);
      chk("rst_full",   full_out, 1'b0);
      chk("rst_one",    one_left_out, 1'b0);
      chk("rst_dready_rdy0", disp_ready_out, 1'b0);
      rdy_in = 1'b1;
      #1;
      chk("rst_dready_rdy1", disp_ready_out, 1'b1);
      @(negedge clk_in); rst_n_in = 1'b1;
      @(posedge clk_in); #1;

      for (int v = 0; v < vt.size(); v++) begin
         set_in(vt[v].dv, vt[v].qj, vt[v].qk, vt[v].alu, vt[v].mem, vt[v].ir, vt[v].fl);
         mid();
         chk($sformatf("vec%0d_busy", v),   busy_out,        vt[v].busy);
         chk($sformatf("vec%0d_iv", v),     issue_valid_out, vt[v].iv);
         chk($sformatf("vec%0d_islot", v),  issue_slot_out,  vt[v].islot);
         chk($sformatf("vec%0d_dslot", v),  disp_slot_out,   vt[v].dslot);
         chk($sformatf("vec%0d_dready", v), disp_ready_out,  vt[v].dready);
         chk($sformatf("vec%0d_full", v),   full_out,        vt[v].full);
         chk($sformatf("vec%0d_one", v),    one_left_out,    vt[v].one);
         fin();
      end

      // Slots 2 and 5 wait on tag 4, slot 1 on tag 9, the rest on tag 6.
      cyc(1, 6, 0, 0, 0, 0, 0);
      cyc(1, 9, 0, 0, 0, 0, 0);
      cyc(1, 4, 0, 0, 0, 0, 0);
      cyc(1, 6, 0, 0, 0, 0, 0);
      cyc(1, 0, 6, 0, 0, 0, 0);
      cyc(1, 0, 4, 0, 0, 0, 0);
      set_in(0, 0, 0, 4, 0, 0, 0); mid(); expect_issue("wake4_pre", 0, 0); fin();
      set_in(0, 0, 0, 0, 0, 0, 0); mid(); expect_issue("older2_first", 1, 2); fin();
      set_in(0, 0, 0, 0, 0, 1, 0); mid(); expect_issue("older2_hold", 1, 2); fin();
      set_in(0, 0, 0, 0, 0, 0, 0); mid(); expect_issue("then5", 1, 5); fin();
      set_in(0, 0, 0, 0, 9, 0, 0); mid(); expect_issue("lock5_a", 1, 5); fin();
      set_in(0, 0, 0, 0, 0, 0, 0); mid(); expect_issue("lock5_b", 1, 5); fin();
      set_in(0, 0, 0, 0, 0, 1, 0); mid(); expect_issue("lock5_acc", 1, 5); fin();
      set_in(0, 0, 0, 0, 0, 0, 0); mid(); expect_issue("after5_is1", 1, 1); fin();
      cyc(1, 6, 0, 0, 0, 0, 0);
      cyc(1, 6, 0, 0, 0, 0, 0);
      set_in(0, 0, 0, 0, 0, 0, 1); mid();
      chk("flush_pre_busy", busy_out, 16'h003f);
      expect_issue("flush_cycle", 0, 0);
      fin();
      set_in(0, 0, 0, 0, 0, 0, 0); mid();
      chk("flush_post_busy", busy_out, 16'h0000);
      expect_issue("flush_post", 0, 0);
      fin();

      // Asynchronous reset in the middle of a cycle with work pending.
      cyc(1, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0);
      cyc(1, 2, 0, 0, 0, 0, 0);
      set_in(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk_in);
      #2 rst_n_in = 1'b0;
      #1;
      chk("arst_busy", busy_out, 16'h0000);
      chk("arst_iv",   issue_valid_out, 1'b0);
      chk("arst_full", full_out, 1'b0);
      model_reset();
      @(posedge clk_in); #1;
      rst_n_in = 1'b1;

      for (int n = 0; n < 3000; n++) begin
         rdy_in = ($urandom_range(0, 9) != 0);
         set_in($urandom_range(0, 1) == 1,
                ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 7)) : 4'd0,
                ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 7)) : 4'd0,
                ($urandom_range(0, 1) == 0) ? 4'($urandom_range(1, 7)) : 4'd0,
                ($urandom_range(0, 1) == 0) ? 4'($urandom_range(1, 7)) : 4'd0,
                $urandom_range(0, 2) != 0,
                $urandom_range(0, 60) == 0);
         mid();
         fin();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rs_issue_ctrl.md
# rs_issue_ctrl

Control half of a 16-entry reservation station. It allocates slots to dispatched instructions and tracks operand tags, waking them up from the two CDBs (ALU, memory). It then selects the oldest ready entry and issues it to the functional unit with a valid/ready handshake. It sits between decode/dispatch and the ALU; the RS value/opcode storage is a separate datapath addressed by the slot indices this block emits.

## Interface
Parameters:
- `ENTRIES`, 16: number of RS slots; slot index is 4 bits.
- `ROB_W`, 4: ROB tag width. Tag 0 means "no dependency / idle bus".

Ports:
- `clk_in`  in  1  clock.
- `rst_n_in`  in  1  reset, asynchronous, active-low.
- `rdy_in`  in  1  global enable. When low, no state changes, `issue_valid_out`=0 and `disp_ready_out`=0.
- `flush_in`  in  1  mispredict flush; clears all entries at the next edge.
- `disp_valid_in`  in  1  dispatch request.
- `disp_ready_out`  out  1  = `rdy_in` & at least one free slot; independent of `disp_valid_in`.
- `disp_qj_in`, `disp_qk_in`  in  ROB_W  source tags at dispatch.
- `disp_slot_out`  out  4  lowest-index free slot; the datapath writes operands there.
- `cdb_alu_rob_id_in`, `cdb_mem_rob_id_in`  in  ROB_W  broadcast tags (0 = idle).
- `issue_valid_out`  out  1  an entry is offered to the FU.
- `issue_ready_in`  in  1  FU accepts.
- `issue_slot_out`  out  4  slot being offered.
- `busy_out`  out  16  per-slot occupied.
- `full_out`  out  1  no free slot.
- `one_left_out`  out  1  exactly one free slot.

## Operation
- Per-slot state: FREE → WAIT (any Q≠0) or READY (both Q=0) → OFFERED → FREE.
- Dispatch fires on `disp_valid_in & disp_ready_out & ~flush_in` and writes slot `disp_slot_out`.
- Dispatch tags are bypassed against the same-cycle CDBs: a tag equal to a non-zero CDB id is stored as 0.
- Wakeup: every busy slot clears Qj/Qk when it matches a non-zero CDB id. Both buses are checked every cycle. Both operands may wake on the same edge, from different buses.
- WAIT → READY at the edge where both Q become 0.
- Age: a 16×16 age matrix. On allocating slot s, s is marked younger than every currently busy slot. Freed slots are ignored.
- Select: the oldest READY slot, combinational from registered state.
- Once `issue_valid_out` rises and no handshake occurs, that slot is locked as OFFERED. `issue_slot_out` is held stable and `issue_valid_out` stays high until `issue_ready_in`, even if an older slot becomes ready.
- Handshake (`issue_valid_out & issue_ready_in`): the slot returns to FREE at the edge.
- A freed slot cannot be re-dispatched in the same cycle; `disp_ready_out` uses registered busy.
- Flush: all slots go FREE, the age matrix and lock clear, and dispatch is ignored. `issue_valid_out` is forced 0 during the flush cycle.
- Flush has priority over dispatch, wakeup and issue.
- `rst_n_in` low mid-operation: all state clears immediately.

## Timing
- Reset values:
  - `busy_out`=0, `full_out`=0, `one_left_out`=0.
  - `issue_valid_out`=0, `issue_slot_out`=0, `disp_slot_out`=0.
  - `disp_ready_out`=`rdy_in`.
- Dispatch with ready operands at edge T → `issue_valid_out` in the cycle after T (1-cycle latency).
- CDB tag present in cycle T → the dependent entry can issue in cycle T+1.
- Slot freed by a handshake at edge T → shows as free and dispatchable in cycle T+1.
- `full_out` and `one_left_out` are derived from registered busy only.

## Structure
- Shared header/package: `ROB_W`, `RS_ENTRIES`, `TAG_NONE`=0, slot-state encoding (FREE/WAIT/READY/OFFERED).
- One sub-module, `rs_age_select`: holds the age matrix and implements allocate/free updates plus the oldest-ready picker (ready mask in, index and valid out).
- Free-slot search and vacancy counting stay in the top level.

## Test plan
- Reset, then dispatch 16 entries with Qj=Qk=0 and hold `issue_ready_in`=0. Required: after the 16th, `full_out`=1 and `disp_ready_out`=0; at 15 occupied, `one_left_out`=1. `issue_slot_out`=0 stays stable while the offer is held.
- Dispatch slot 0 (Qj=3) then slot 1 (Qk=5). Put 5 on the mem CDB, then 3 on the ALU CDB. Required: slot 1 issues first; slot 0 issues the cycle after tag 3.
- Dispatch with Qj=7 while the ALU CDB carries 7 in the same cycle. Required: the entry is READY and issues the next cycle.
- Slots 2 (older) and 5 both waiting on tag 4. Broadcast 4. Required: slot 2 offered first, slot 5 after the handshake.
- Offer slot 5 with `issue_ready_in`=0 while older slot 1 becomes ready. Required: `issue_slot_out` stays 5 until accepted, then 1 is offered.
- Assert `flush_in` with 6 busy entries and one offer pending. Required: next cycle `busy_out`=0 and `issue_valid_out`=0. Pulsing `rst_n_in` low mid-stream gives the same result asynchronously.
